// File: rtl/uart_word_rx_if.sv
// Word handshake bus between the UART word receiver and whatever consumes its words.
// The producer drives data and valid. The consumer answers with ready.
interface uart_word_rx_if #(
    parameter int WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] word_data;
    logic                    word_valid;
    logic                    word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs WORD_BYTES bytes into a little-endian word behind a valid/ready holding register.
// It also reports framing errors, inter-byte timeouts and words dropped by overrun.
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int WORD_BYTES   = 4,
    parameter int TIMEOUT_BITS = 20,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_in,
    uart_word_rx_if.master    word_if,
    output logic              frame_err,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int WORD_W    = 8 * WORD_BYTES;
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W     = $clog2(8 + 1);
    localparam int IDX_W     = $clog2(WORD_BYTES + 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_LIMIT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]      asm_q, asm_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_q, frame_d;
    logic                   tmo_err_q, tmo_err_d;
    logic                   ovr_q, ovr_d;
    logic                   accept;
    logic                   baud_tick;

    // Synchroniser flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_in};
        end
    end

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign accept    = valid_q && word_if.word_ready;
    assign baud_tick = (baud_q == BAUD_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            asm_q     <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            tmo_err_q <= tmo_err_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        valid_d   = valid_q;
        frame_d   = 1'b0;
        tmo_err_d = 1'b0;
        ovr_d     = 1'b0;

        if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // The timeout only runs while a partial word is waiting for its next byte.
                if (!rxs) begin
                    state_d = START;
                    baud_d  = BAUD_HALF;
                    tmo_d   = '0;
                end else if (idx_q != '0) begin
                    if (tmo_q == TMO_LAST) begin
                        idx_d     = '0;
                        tmo_d     = '0;
                        tmo_err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end else begin
                    tmo_d = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        baud_d  = BAUD_FULL;
                        bit_d   = '0;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = {rxs, shift_q[7:1]};
                    baud_d  = BAUD_FULL;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (rxs) begin
                        asm_d[8*idx_q +: 8] = shift_q;
                        state_d             = IDLE;
                        // A word completing during a same-cycle accept reloads with no valid gap.
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            if (!valid_q || accept) begin
                                data_d  = asm_d;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        frame_d = 1'b1;
                        idx_d   = '0;
                        state_d = BREAK;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign word_if.word_data  = data_q;
    assign word_if.word_valid = valid_q;
    assign frame_err          = frame_q;
    assign timeout_err        = tmo_err_q;
    assign overrun_err        = ovr_q;

endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- Parametrised UART receiver that assembles WORD_BYTES consecutive bytes into one little-endian word and presents it on a valid/ready interface.
- Successor to the fixed 4-byte, 9600-baud operand-capture front end of the UART calculator; feeds operand/opcode registers of calculator and future command decoders.
- Adds features the fixed version lacks: configurable baud and word width, framing-error detection, inter-byte timeout that discards partial words, and overrun reporting.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); must be >= 4.
WORD_BYTES, 4, bytes per assembled word; must be >= 1.
TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one word before the partial word is discarded.
SYNC_STAGES, 2, flip-flops in the uart_in synchroniser; must be >= 2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
uart_in  in  1  serial line; idles high; 8N1, LSB first.
word_data  out  8*WORD_BYTES  assembled word; first received byte in bits [7:0].
word_valid  out  1  word_data holds an unconsumed word.
word_ready  in  1  consumer accepts word when word_valid && word_ready at a rising clk edge.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
timeout_err  out  1  one-cycle pulse: partial word discarded by timeout.
overrun_err  out  1  one-cycle pulse: completed word dropped because the holding register was full.

Behaviour:
- Reset (rst_n low, async): synchroniser flops = 1, FSM = IDLE, byte index = 0, bit/baud/timeout counters = 0, word_data = 0, word_valid = 0, all error pulses = 0. Reset mid-byte or mid-word discards all partial data; no error pulse is generated.
- All line decisions use the synchronised signal rxs (SYNC_STAGES cycles of delay).
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE -> START on rxs = 0. Baud counter loads CLKS_PER_BIT/2.
- START at half-bit: rxs = 1 -> IDLE (glitch; no byte, no error). rxs = 0 -> DATA, baud counter = CLKS_PER_BIT.
- DATA: sample rxs every CLKS_PER_BIT clocks at bit centre. Shift in LSB first. After 8 samples -> STOP.
- STOP at stop-bit centre:
  - rxs = 1: byte written to slot index ([8*idx+7:8*idx] of the assembly register), idx++, -> IDLE.
  - rxs = 0: frame_err pulse, byte dropped, idx cleared to 0, -> BREAK.
- BREAK -> IDLE when rxs = 1.
- Word completion: when the stored byte makes idx = WORD_BYTES, idx -> 0 in the same cycle.
  - If holding register is free (word_valid = 0, or word_valid && word_ready in this cycle), the word is loaded into word_data and word_valid = 1 on the next edge. Latency is 1 clk after the stop-bit centre sample.
  - Otherwise overrun_err pulses, the new word is dropped, and word_data is held unchanged.
- Simultaneous accept and completion: the new word is loaded and word_valid stays 1 with no gap.
- Accept without completion: word_valid -> 0 next edge. word_data keeps its last value.
- word_data is stable while word_valid = 1 and word_ready = 0.
- Timeout: counts clocks while FSM = IDLE and idx > 0; clears on any START entry.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT: idx -> 0, partial bytes discarded, timeout_err pulses once.
  - No timeout when idx = 0.
- Counter widths: each counter is sized by $clog2 of its terminal count + 1. No wrap is reachable.
- Simultaneous frame_err and timeout cannot occur: the timeout counter only runs in IDLE.

Test Plan:
All scenarios use CLKS_PER_BIT=16, WORD_BYTES=4, TIMEOUT_BITS=20.
1. Send bytes EF, BE, AD, DE; word_ready = 1 -> single word_valid pulse with word_data = 32'hDEADBEEF, 1 clk after 4th stop-bit centre; no errors.
2. word_ready = 0; send word 0x11223344 then word 0x55667788 -> word_data stays 0x11223344 with valid held; one overrun_err pulse at 2nd completion. Then raise word_ready -> valid drops next cycle.
3. Send byte 0x12, then byte 0x34 with stop bit = 0 -> frame_err pulse; line high; send 0xA1, 0xB2, 0xC3, 0xD4 -> word_data = 32'hD4C3B2A1 (0x12 discarded).
4. Send 0x01, 0x02; idle 25 bit-times (400 clk) -> exactly one timeout_err pulse. Then send 0x10, 0x20, 0x30, 0x40 -> word_data = 32'h40302010.
5. Pulse uart_in low for 5 clk -> no byte stored, no error. Following valid 4-byte word assembles correctly.
6. Assert rst_n = 0 mid-DATA of byte 3 -> all outputs 0 immediately (async). After release, a fresh 4-byte word 0xCAFEF00D is received intact.
